// File: rtl/rhd_pkg.sv
// Shared opcodes, ROM map and command classification for the RHD2000 SPI responder.
package rhd_pkg;

    typedef enum logic [2:0] {
        CMD_CONVERT,
        CMD_CALIBRATE,
        CMD_CLEAR,
        CMD_WRITE,
        CMD_READ,
        CMD_OTHER
    } cmd_kind_t;

    localparam logic [1:0]  OP_CONVERT   = 2'b00;
    localparam logic [1:0]  OP_WRITE     = 2'b10;
    localparam logic [1:0]  OP_READ      = 2'b11;
    localparam logic [15:0] OP_CALIBRATE = 16'h5500;
    localparam logic [15:0] OP_CLEAR     = 16'h6A00;

    localparam int unsigned NUM_RW_REGS    = 40;
    localparam logic [5:0]  ROM_INTAN_BASE = 6'd40;
    localparam logic [5:0]  ROM_ZERO       = 6'd59;
    localparam logic [5:0]  ROM_DIE_REV    = 6'd60;
    localparam logic [5:0]  ROM_UNIPOLAR   = 6'd61;
    localparam logic [5:0]  ROM_NUM_AMPS   = 6'd62;
    localparam logic [5:0]  ROM_CHIP_ID    = 6'd63;

    function automatic logic [7:0] intan_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h49;
            3'd1:    b = 8'h4E;
            3'd2:    b = 8'h54;
            3'd3:    b = 8'h41;
            default: b = 8'h4E;
        endcase
        return b;
    endfunction

    function automatic cmd_kind_t classify(input logic [15:0] cmd);
        cmd_kind_t kind;
        case (cmd[15:14])
            OP_CONVERT: kind = CMD_CONVERT;
            OP_WRITE:   kind = CMD_WRITE;
            OP_READ:    kind = CMD_READ;
            default: begin
                if (cmd == OP_CALIBRATE)  kind = CMD_CALIBRATE;
                else if (cmd == OP_CLEAR) kind = CMD_CLEAR;
                else                      kind = CMD_OTHER;
            end
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/rhd_spi_shifter.sv
// SPI slave front end: input synchronizers, edge detection, 16-bit shift in/out,
// and end-of-frame strobes.
module rhd_spi_shifter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    input  logic [15:0] tx_word,
    output logic        miso_raw,
    output logic        frame_end,
    output logic [15:0] rx_word,
    output logic        frame_error
);

    logic [1:0]  sclk_sync, mosi_sync, cs_sync;
    logic        sclk_q, cs_q, in_frame;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [4:0]  bit_cnt;
    logic [15:0] rx_shift, tx_shift;

    // CS sync resets low: a frame already running at reset release is never
    // joined, because in_frame only sets on an observed CS fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs};
            sclk_q    <= sclk_sync[1];
            cs_q      <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_q;
    assign sclk_fall = ~sclk_sync[1] & sclk_q;
    assign cs_rise   = cs_sync[1] & ~cs_q;
    assign cs_fall   = ~cs_sync[1] & cs_q;
    assign frame_end = cs_rise & in_frame & (bit_cnt == 5'd16);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_frame    <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            if (cs_fall) begin
                in_frame <= 1'b1;
                bit_cnt  <= '0;
                tx_shift <= tx_word;
            end else if (cs_rise) begin
                in_frame    <= 1'b0;
                frame_error <= in_frame & (bit_cnt != 5'd16);
            end else if (in_frame) begin
                if (sclk_rise && bit_cnt != 5'd16) begin
                    rx_shift <= {rx_shift[14:0], mosi_sync[1]};
                    bit_cnt  <= bit_cnt + 5'd1;
                end
                if (sclk_fall) begin
                    tx_shift <= {tx_shift[14:0], 1'b0};
                end
            end
        end
    end

    assign rx_word  = rx_shift;
    assign miso_raw = tx_shift[15];

endmodule

// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI responder: command decode, 64x8 register map, two-frame
// result pipeline and optional MISO delay line.
module rhd_spi_responder #(
    parameter logic [15:0] STARTING_SEED   = 16'd0,
    parameter int unsigned NUM_CHANNELS    = 64,
    parameter logic [7:0]  CHIP_ID         = 8'd4,
    parameter int unsigned MISO_DELAY_CLKS = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    output logic        frame_done,
    output logic [15:0] last_cmd,
    output logic        frame_error
);
    import rhd_pkg::*;

    logic        miso_raw, frame_end;
    logic [15:0] rx_word, res1, res2, result;
    logic [7:0]  regs [NUM_RW_REGS];
    logic [7:0]  rd_data;
    logic [5:0]  addr;
    cmd_kind_t   kind;
    // Only the low byte of the CONVERT counter is ever visible, so an 8-bit
    // counter wraps identically to the 16-bit one.
    logic [7:0]  conv_cnt, cnt_next;

    rhd_spi_shifter u_shifter (
        .clk         (clk),
        .rstn        (rstn),
        .sclk        (SCLK),
        .mosi        (MOSI),
        .cs          (CS),
        .tx_word     (res2),
        .miso_raw    (miso_raw),
        .frame_end   (frame_end),
        .rx_word     (rx_word),
        .frame_error (frame_error)
    );

    assign addr = rx_word[13:8];
    assign kind = classify(rx_word);

    always_comb begin
        rd_data = '0;
        if ({26'd0, addr} < NUM_RW_REGS) begin
            rd_data = regs[addr];
        end else if (addr <= ROM_INTAN_BASE + 6'd4) begin
            rd_data = intan_byte(3'(addr - ROM_INTAN_BASE));
        end else begin
            case (addr)
                ROM_ZERO:                  rd_data = 8'h00;
                ROM_DIE_REV, ROM_UNIPOLAR: rd_data = 8'h01;
                ROM_NUM_AMPS:              rd_data = 8'(NUM_CHANNELS);
                ROM_CHIP_ID:               rd_data = CHIP_ID;
                default:                   rd_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        result   = '0;
        cnt_next = conv_cnt;
        case (kind)
            CMD_CONVERT: begin
                if ({26'd0, addr} < NUM_CHANNELS)
                    result = STARTING_SEED + {2'b00, addr, 8'h00} + {8'h00, conv_cnt};
                cnt_next = conv_cnt + 8'd1;
            end
            CMD_CLEAR: cnt_next = '0;
            CMD_WRITE: result = {8'hFF, rx_word[7:0]};
            CMD_READ:  result = {8'h00, rd_data};
            default:   result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res1       <= '0;
            res2       <= '0;
            last_cmd   <= '0;
            frame_done <= 1'b0;
            conv_cnt   <= '0;
            regs       <= '{default: '0};
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                res1     <= result;
                res2     <= res1;
                last_cmd <= rx_word;
                conv_cnt <= cnt_next;
                if (kind == CMD_WRITE && {26'd0, addr} < NUM_RW_REGS)
                    regs[addr] <= rx_word[7:0];
            end
        end
    end

    generate
        if (MISO_DELAY_CLKS == 0) begin : g_no_delay
            assign MISO = miso_raw;
        end else begin : g_delay
            logic [MISO_DELAY_CLKS-1:0] dly;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dly <= '0;
                end else begin
                    dly[0] <= miso_raw;
                    for (int unsigned i = 1; i < MISO_DELAY_CLKS; i++)
                        dly[i] <= dly[i-1];
                end
            end
            assign MISO = dly[MISO_DELAY_CLKS-1];
        end
    endgenerate

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Bench for rhd_spi_responder: directed scenarios plus random frames checked
// against a command-level reference model.
module tb_rhd_spi_responder;

    logic clk = 1'b0;
    logic rstn, SCLK, MOSI, CS;
    logic miso_def, miso_seed, miso_dly;
    logic done_def, done_seed, done_dly;
    logic err_def, err_seed, err_dly;
    logic [15:0] last_def, last_seed, last_dly;

    always #5 clk = ~clk;

    rhd_spi_responder dut (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
        .MISO(miso_def), .frame_done(done_def), .last_cmd(last_def), .frame_error(err_def));

    rhd_spi_responder #(.STARTING_SEED(16'd64), .NUM_CHANNELS(48)) dut_seed (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
        .MISO(miso_seed), .frame_done(done_seed), .last_cmd(last_seed), .frame_error(err_seed));

    rhd_spi_responder #(.MISO_DELAY_CLKS(5)) dut_dly (
        .clk(clk), .rstn(rstn), .SCLK(SCLK), .MOSI(MOSI), .CS(CS),
        .MISO(miso_dly), .frame_done(done_dly), .last_cmd(last_dly), .frame_error(err_dly));

    int checks = 0;
    int errors = 0;
    int done_cnt, err_cnt, lag_hold;
    logic [15:0] rsp_def, rsp_seed;
    logic [7:0]  miso_hist = '0;

    always @(negedge clk) miso_hist <= {miso_hist[6:0], miso_def};

    // Reference model: model 0 = default build, model 1 = seed 64 / 48 channels.
    logic [7:0]  mregs [64];
    int          mcnt  [2];
    int          mseed [2] = '{0, 64};
    int          mchan [2] = '{64, 48};
    logic [7:0]  intan [5] = '{8'h49, 8'h4E, 8'h54, 8'h41, 8'h4E};
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] mlast;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input int m, input int a);
        if (a < 40) return mregs[a];
        if (a < 45) return intan[a-40];
        case (a)
            60, 61:  return 8'h01;
            62:      return 8'(mchan[m]);
            63:      return 8'h04;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] model_eval(input int m, input logic [15:0] cmd);
        int a;
        logic [15:0] r;
        a = int'(cmd[13:8]);
        r = 16'h0000;
        case (cmd[15:14])
            2'b00: begin
                if (a < mchan[m]) r = 16'((mseed[m] + a * 256 + mcnt[m] % 256) % 65536);
                mcnt[m] = (mcnt[m] + 1) % 65536;
            end
            2'b01:   if (cmd == 16'h6A00) mcnt[m] = 0;
            2'b10:   r = {8'hFF, cmd[7:0]};
            default: r = {8'h00, model_read(m, a)};
        endcase
        return r;
    endfunction

    task automatic model_reset();
        foreach (mregs[i]) mregs[i] = 8'h00;
        mcnt[0] = 0;
        mcnt[1] = 0;
        q0 = {16'h0000, 16'h0000};
        q1 = {16'h0000, 16'h0000};
        mlast = 16'h0000;
    endtask

    task automatic tick();
        @(negedge clk);
        done_cnt += int'(done_def) + int'(done_seed) + int'(done_dly);
        err_cnt  += int'(err_def) + int'(err_seed) + int'(err_dly);
        if (lag_hold > 0) lag_hold--;
        else check("miso_lag5", {15'd0, miso_dly}, {15'd0, miso_hist[4]});
    endtask

    task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int rst_at);
        logic [19:0] bits;
        bits = {cmd, 4'($urandom)};
        rsp_def = '0;
        rsp_seed = '0;
        done_cnt = 0;
        err_cnt = 0;
        CS = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                lag_hold = 10;
                repeat (2) tick();
                check("rst_mid_miso", {15'd0, miso_def}, 16'h0000);
                check("rst_mid_last_cmd", last_def, 16'h0000);
                rstn = 1'b1;
                tick();
            end
            MOSI = bits[19-i];
            repeat (4) tick();
            if (i < 16) begin
                rsp_def  = {rsp_def[14:0], miso_def};
                rsp_seed = {rsp_seed[14:0], miso_seed};
            end
            SCLK = 1'b1;
            repeat (4) tick();
            SCLK = 1'b0;
        end
        repeat (4) tick();
        CS = 1'b1;
        repeat (8) tick();
    endtask

    task automatic do_frame(input logic [15:0] cmd, input int nbits);
        logic [15:0] e0, e1;
        e0 = q0[0];
        e1 = q1[0];
        spi_frame(cmd, nbits, -1);
        if (nbits >= 16) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            q0.push_back(model_eval(0, cmd));
            q1.push_back(model_eval(1, cmd));
            if (cmd[15:14] == 2'b10 && cmd[13:8] < 6'd40) mregs[cmd[13:8]] = cmd[7:0];
            mlast = cmd;
            check("rsp", rsp_def, e0);
            check("rsp_seed", rsp_seed, e1);
            check("done_pulses", 16'(done_cnt), 16'd3);
            check("no_frame_error", 16'(err_cnt), 16'd0);
        end else begin
            check("partial_rsp", rsp_def, 16'(e0 >> (16 - nbits)));
            check("error_pulses", 16'(err_cnt), 16'd3);
            check("no_done", 16'(done_cnt), 16'd0);
        end
        check("last_cmd", last_def, mlast);
        check("last_cmd_seed", last_seed, mlast);
        check("last_cmd_dly", last_dly, mlast);
    endtask

    initial begin
        logic [15:0] pending, cmd;
        int nb, r;
        rstn = 1'b0;
        SCLK = 1'b0;
        MOSI = 1'b0;
        CS = 1'b1;
        lag_hold = 12;
        done_cnt = 0;
        err_cnt = 0;
        model_reset();
        repeat (3) tick();
        check("reset_last_cmd", last_def, 16'h0000);
        check("reset_miso", {15'd0, miso_def}, 16'h0000);
        check("reset_done", {15'd0, done_def}, 16'h0000);
        check("reset_error", {15'd0, err_def}, 16'h0000);
        err_cnt = 0;
        rstn = 1'b1;
        repeat (6) tick();
        check("release_no_error", 16'(err_cnt), 16'd0);

        // ROM "INTAN" reads with two-frame latency
        do_frame(16'hE800, 16);
        do_frame(16'hE900, 16);
        do_frame(16'hEA00, 16);
        check("intan_I", rsp_def, 16'h0049);
        do_frame(16'hFF00, 16);
        check("intan_N", rsp_def, 16'h004E);
        do_frame(16'hFE00, 16);
        check("intan_T", rsp_def, 16'h0054);

        // Write then read back
        do_frame(16'h85A7, 16);
        do_frame(16'hC500, 16);
        do_frame(16'hC000, 16);
        check("write_echo", rsp_def, 16'hFFA7);
        do_frame(16'hC000, 16);
        check("read_back", rsp_def, 16'h00A7);

        // CONVERT ramp on the seed=64 build, then CLEAR
        do_frame(16'h0000, 16);
        do_frame(16'h0100, 16);
        do_frame(16'h0201, 16);
        check("conv0_seed", rsp_seed, 16'h0040);
        do_frame(16'hC000, 16);
        check("conv1_seed", rsp_seed, 16'h0141);
        do_frame(16'hC000, 16);
        check("conv2_seed", rsp_seed, 16'h0242);
        do_frame(16'h6A00, 16);
        do_frame(16'h0000, 16);
        do_frame(16'hC000, 16);
        do_frame(16'hC000, 16);
        check("conv_after_clear", rsp_seed, 16'h0040);

        // Aborted frame leaves the pipeline untouched
        do_frame(16'h8312, 16);
        pending = q0[0];
        do_frame(16'hC100, 9);
        do_frame(16'hC100, 16);
        check("after_abort", rsp_def, pending);

        // Reset mid-frame
        spi_frame(16'hE800, 16, 7);
        model_reset();
        check("post_rst_last_cmd", last_def, 16'h0000);
        check("post_rst_miso", {15'd0, miso_def}, 16'h0000);
        do_frame(16'hC000, 16);
        check("post_rst_rsp", rsp_def, 16'h0000);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            nb = 16;
            case (r)
                0, 1, 2: cmd = {2'b00, 14'($urandom)};
                3:       cmd = {2'b10, 14'($urandom)};
                4:       cmd = {2'b10, 6'($urandom_range(0, 39)), 8'($urandom)};
                5, 6:    cmd = {2'b11, 14'($urandom)};
                7: begin
                    case ($urandom_range(0, 2))
                        0:       cmd = 16'h5500;
                        1:       cmd = 16'h6A00;
                        default: cmd = {2'b01, 14'($urandom)};
                    endcase
                end
                8: begin
                    cmd = 16'($urandom);
                    nb = int'($urandom_range(1, 15));
                end
                default: begin
                    cmd = 16'($urandom);
                    nb = int'($urandom_range(17, 20));
                end
            endcase
            do_frame(cmd, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
